hoplite_router: RTL and testbench
=================================

HOPLITE_ROUTER -- requirements
Module: hoplite_router

Interface
REQ-001 X_W, 2, X address width; Y_W, 2, Y address width; D_W, 32, payload width.
REQ-002 X, 0, this router's X coordinate; Y, 0, this router's Y coordinate.
REQ-003 STARVE_MAX, 8, consecutive PE denials before the starvation flag asserts; legal range 1..255.
REQ-004 clk  in  1  sole clock; rst  in  1  synchronous active-high reset.
REQ-005 n_x/n_y/n_d/n_v  in  X_W/Y_W/D_W/1  north input packet (dest x, dest y, payload, valid).
REQ-006 w_x/w_y/w_d/w_v  in  X_W/Y_W/D_W/1  west input packet.
REQ-007 i_x/i_y/i_d/i_v  in  X_W/Y_W/D_W/1  PE injection packet.
REQ-008 e_x/e_y/e_d/e_v  out  X_W/Y_W/D_W/1  registered east output packet.
REQ-009 s_x/s_y/s_d/s_v  out  X_W/Y_W/D_W/1  registered south output packet.
REQ-010 o_d/o_v  out  D_W/1  registered PE ejection (shares the south channel).
REQ-011 i_ack  out  1  combinational; PE packet accepted this cycle.
REQ-012 i_starve  out  1  registered; starvation counter equals STARVE_MAX.

Function
REQ-013 Define the south channel as the single resource driving either s_* or o_*; s_v and o_v are never both 1.
REQ-014 A packet is local when x==X and y==Y; it prefers south when x==X; otherwise it prefers east.
REQ-015 N valid always takes the south channel: local -> o, else -> s; N never deflects.
REQ-016 W preferring south takes the south channel unless N is valid or the PE holds priority (REQ-018); otherwise W deflects east.
REQ-017 W preferring east always takes east.
REQ-018 PE preferring south is acked when N is invalid and either W does not claim the south channel, or i_starve=1 (PE then beats W; W deflects east).
REQ-019 PE preferring east is acked only when w_v=0; i_starve has no effect on east contention.
REQ-020 i_ack=0 whenever i_v=0; the PE holds its packet stable until acked.
REQ-021 Latency: a decision made in cycle t appears on e_*/s_*/o_* at cycle t+1; unused output valids are 0, and data fields hold their previous values.
REQ-022 Starvation counter (8-bit): if i_v && !i_ack, increment, saturating at STARVE_MAX; if i_ack or !i_v, clear to 0.
REQ-023 i_starve asserts the cycle after the counter reaches STARVE_MAX; it clears the cycle after the next i_ack.
REQ-024 No packet is ever dropped or duplicated: each valid N/W input appears on exactly one output one cycle later.

Reset
REQ-025 While rst=1: e_v, s_v, o_v, i_starve and the counter are 0, and all data/address registers are 0.
REQ-026 i_ack=0 during rst regardless of the inputs; in-flight registered packets are discarded by reset.

Configuration
REQ-027 HOPLITE_STATS_EN defined: add outputs defl_cnt (16-bit; increments when W preferring south goes east) and inj_cnt (16-bit; increments on i_ack); both saturate at 0xFFFF and reset to 0.
REQ-028 HOPLITE_STATS_EN undefined: the ports and counters are absent, and all other behaviour is identical.

Structure
REQ-029 Package hoplite_pkg holds typedef enum route_t {RT_NONE, RT_EAST, RT_SOUTH, RT_EJECT} and the default width localparams.
REQ-030 Sub-module hoplite_arb: combinational route decision (inputs: valids, prefer/local flags, i_starve; outputs: route_t per source, i_ack); hoplite_router holds the registers and counters.

Verification (X=1, Y=2, X_W=Y_W=2, STARVE_MAX=3)
REQ-031 n=(1,2,0xA,v) -> next cycle o_v=1, o_d=0xA, s_v=0, e_v=0.
REQ-032 n=(1,0,0xB,v), w=(1,3,0xC,v) -> next cycle s_d=0xB, e_d=0xC with e_x=1 (deflection); i_ack=0 for any i_v.
REQ-033 w=(0,0,0x1,v), i=(1,0,0x2,v) -> i_ack=1; next cycle e_d=0x1, s_d=0x2.
REQ-034 w=(1,0,v) and i=(1,0,v) held for 3 cycles -> i_starve=1 at cycle 4; at cycle 4 i_ack=1, then s_d=PE payload and e_d=W payload.
REQ-035 rst asserted mid-stream with all outputs valid -> next cycle all valids 0, i_starve=0, and the counter restarts from 0.
REQ-036 (STATS) 5 forced deflections followed by 2 injections -> defl_cnt=5, inj_cnt=2.

Source files
------------

// File: rtl/hoplite_pkg.sv
// Shared types and default widths for the Hoplite deflection router.
// Build option: HOPLITE_STATS_EN adds deflection/injection statistics counters.
package hoplite_pkg;

    localparam int unsigned X_W_DEF  = 2;
    localparam int unsigned Y_W_DEF  = 2;
    localparam int unsigned D_W_DEF  = 32;
    localparam int unsigned STARVE_W = 8;
    localparam int unsigned STAT_W   = 16;

    typedef enum logic [1:0] {
        RT_NONE,
        RT_EAST,
        RT_SOUTH,
        RT_EJECT
    } route_t;

endpackage

// File: rtl/hoplite_arb.sv
// Combinational route decision for the three packet sources (N, W, PE).
// The south channel (s or o) is granted to at most one source per cycle.
module hoplite_arb
    import hoplite_pkg::*;
(
    input  logic   n_v,
    input  logic   n_local,
    input  logic   w_v,
    input  logic   w_south,
    input  logic   w_local,
    input  logic   i_v,
    input  logic   i_south,
    input  logic   i_local,
    input  logic   i_starve,
    output route_t n_rt,
    output route_t w_rt,
    output route_t i_rt,
    output logic   i_ack
);

    logic w_claim;
    logic pe_pri;

    assign w_claim = w_v && w_south;
    // A starving PE wins the south channel over W, but never over N.
    assign pe_pri  = i_v && i_south && i_starve && !n_v;

    always_comb begin
        n_rt  = RT_NONE;
        w_rt  = RT_NONE;
        i_rt  = RT_NONE;
        i_ack = 1'b0;

        if (n_v) begin
            n_rt = n_local ? RT_EJECT : RT_SOUTH;
        end

        if (w_v) begin
            if (w_south && !n_v && !pe_pri) begin
                w_rt = w_local ? RT_EJECT : RT_SOUTH;
            end else begin
                w_rt = RT_EAST;
            end
        end

        if (i_v) begin
            if (i_south) begin
                i_ack = !n_v && (!w_claim || i_starve);
            end else begin
                i_ack = !w_v;
            end
            if (i_ack) begin
                i_rt = i_south ? (i_local ? RT_EJECT : RT_SOUTH) : RT_EAST;
            end
        end
    end

endmodule

// File: rtl/hoplite_router.sv
// Hoplite unidirectional-torus deflection router: registered east/south/eject
// outputs, PE injection with starvation boost. Option: HOPLITE_STATS_EN.
module hoplite_router
    import hoplite_pkg::*;
#(
    parameter int unsigned X_W        = X_W_DEF,
    parameter int unsigned Y_W        = Y_W_DEF,
    parameter int unsigned D_W        = D_W_DEF,
    parameter int unsigned X          = 0,
    parameter int unsigned Y          = 0,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [X_W-1:0]   n_x,
    input  logic [Y_W-1:0]   n_y,
    input  logic [D_W-1:0]   n_d,
    input  logic             n_v,
    input  logic [X_W-1:0]   w_x,
    input  logic [Y_W-1:0]   w_y,
    input  logic [D_W-1:0]   w_d,
    input  logic             w_v,
    input  logic [X_W-1:0]   i_x,
    input  logic [Y_W-1:0]   i_y,
    input  logic [D_W-1:0]   i_d,
    input  logic             i_v,
    output logic [X_W-1:0]   e_x,
    output logic [Y_W-1:0]   e_y,
    output logic [D_W-1:0]   e_d,
    output logic             e_v,
    output logic [X_W-1:0]   s_x,
    output logic [Y_W-1:0]   s_y,
    output logic [D_W-1:0]   s_d,
    output logic             s_v,
    output logic [D_W-1:0]   o_d,
    output logic             o_v,
    output logic             i_ack,
    output logic             i_starve
`ifdef HOPLITE_STATS_EN
    ,
    output logic [STAT_W-1:0] defl_cnt,
    output logic [STAT_W-1:0] inj_cnt
`endif
);

    route_t n_rt, w_rt, i_rt;
    logic   i_v_g;
    logic   n_south, n_local, w_south, w_local, i_south, i_local;

    logic [X_W-1:0]      e_x_n, s_x_n;
    logic [Y_W-1:0]      e_y_n, s_y_n;
    logic [D_W-1:0]      e_d_n, s_d_n, o_d_n;
    logic                e_v_n, s_v_n, o_v_n;
    logic [STARVE_W-1:0] cnt, cnt_n;

    assign n_south = (n_x == X_W'(X));
    assign w_south = (w_x == X_W'(X));
    assign i_south = (i_x == X_W'(X));
    assign n_local = n_south && (n_y == Y_W'(Y));
    assign w_local = w_south && (w_y == Y_W'(Y));
    assign i_local = i_south && (i_y == Y_W'(Y));

    // The PE is never acknowledged while reset is held.
    assign i_v_g = i_v && !rst;

    hoplite_arb u_arb (
        .n_v      (n_v),
        .n_local  (n_local),
        .w_v      (w_v),
        .w_south  (w_south),
        .w_local  (w_local),
        .i_v      (i_v_g),
        .i_south  (i_south),
        .i_local  (i_local),
        .i_starve (i_starve),
        .n_rt     (n_rt),
        .w_rt     (w_rt),
        .i_rt     (i_rt),
        .i_ack    (i_ack)
    );

    // Output steering; data fields hold when their channel is idle.
    always_comb begin
        e_v_n = 1'b0;
        e_x_n = e_x;
        e_y_n = e_y;
        e_d_n = e_d;
        s_v_n = 1'b0;
        s_x_n = s_x;
        s_y_n = s_y;
        s_d_n = s_d;
        o_v_n = 1'b0;
        o_d_n = o_d;

        if (w_rt == RT_EAST) begin
            e_v_n = 1'b1;
            e_x_n = w_x;
            e_y_n = w_y;
            e_d_n = w_d;
        end else if (i_rt == RT_EAST) begin
            e_v_n = 1'b1;
            e_x_n = i_x;
            e_y_n = i_y;
            e_d_n = i_d;
        end

        if (n_rt == RT_SOUTH) begin
            s_v_n = 1'b1;
            s_x_n = n_x;
            s_y_n = n_y;
            s_d_n = n_d;
        end else if (w_rt == RT_SOUTH) begin
            s_v_n = 1'b1;
            s_x_n = w_x;
            s_y_n = w_y;
            s_d_n = w_d;
        end else if (i_rt == RT_SOUTH) begin
            s_v_n = 1'b1;
            s_x_n = i_x;
            s_y_n = i_y;
            s_d_n = i_d;
        end

        if (n_rt == RT_EJECT) begin
            o_v_n = 1'b1;
            o_d_n = n_d;
        end else if (w_rt == RT_EJECT) begin
            o_v_n = 1'b1;
            o_d_n = w_d;
        end else if (i_rt == RT_EJECT) begin
            o_v_n = 1'b1;
            o_d_n = i_d;
        end
    end

    // Starvation counter: counts consecutive denials, saturating.
    always_comb begin
        cnt_n = '0;
        if (i_v_g && !i_ack) begin
            cnt_n = (cnt == STARVE_W'(STARVE_MAX)) ? cnt : cnt + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_x      <= '0;
            e_y      <= '0;
            e_d      <= '0;
            e_v      <= 1'b0;
            s_x      <= '0;
            s_y      <= '0;
            s_d      <= '0;
            s_v      <= 1'b0;
            o_d      <= '0;
            o_v      <= 1'b0;
            cnt      <= '0;
            i_starve <= 1'b0;
        end else begin
            e_x      <= e_x_n;
            e_y      <= e_y_n;
            e_d      <= e_d_n;
            e_v      <= e_v_n;
            s_x      <= s_x_n;
            s_y      <= s_y_n;
            s_d      <= s_d_n;
            s_v      <= s_v_n;
            o_d      <= o_d_n;
            o_v      <= o_v_n;
            cnt      <= cnt_n;
            i_starve <= (cnt_n == STARVE_W'(STARVE_MAX));
        end
    end

`ifdef HOPLITE_STATS_EN
    logic defl_ev;

    assign defl_ev = w_v && w_south && (w_rt == RT_EAST);

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            defl_cnt <= '0;
            inj_cnt  <= '0;
        end else begin
            if (defl_ev && (defl_cnt != {STAT_W{1'b1}})) begin
                defl_cnt <= defl_cnt + STAT_W'(1);
            end
            if (i_ack && (inj_cnt != {STAT_W{1'b1}})) begin
                inj_cnt <= inj_cnt + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_hoplite_router.sv
// Directed bench for hoplite_router at X=1, Y=2 with STARVE_MAX=3.
module tb_hoplite_router;

    typedef struct packed {
        logic [1:0]  x;
        logic [1:0]  y;
        logic [31:0] d;
        logic        v;
    } pkt_t;

    typedef struct {
        pkt_t        n;
        pkt_t        w;
        pkt_t        i;
        logic        ack;
        pkt_t        e;
        pkt_t        s;
        logic        ov;
        logic [31:0] od;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  n_x = '0, n_y = '0, w_x = '0, w_y = '0, i_x = '0, i_y = '0;
    logic [31:0] n_d = '0, w_d = '0, i_d = '0;
    logic        n_v = 1'b0, w_v = 1'b0, i_v = 1'b0;
    logic [1:0]  e_x, e_y, s_x, s_y;
    logic [31:0] e_d, s_d, o_d;
    logic        e_v, s_v, o_v, i_ack, i_starve;
`ifdef HOPLITE_STATS_EN
    logic [15:0] defl_cnt, inj_cnt;
`endif

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    hoplite_router #(
        .X_W(2), .Y_W(2), .D_W(32), .X(1), .Y(2), .STARVE_MAX(3)
    ) dut (
        .clk(clk), .rst(rst),
        .n_x(n_x), .n_y(n_y), .n_d(n_d), .n_v(n_v),
        .w_x(w_x), .w_y(w_y), .w_d(w_d), .w_v(w_v),
        .i_x(i_x), .i_y(i_y), .i_d(i_d), .i_v(i_v),
        .e_x(e_x), .e_y(e_y), .e_d(e_d), .e_v(e_v),
        .s_x(s_x), .s_y(s_y), .s_d(s_d), .s_v(s_v),
        .o_d(o_d), .o_v(o_v),
        .i_ack(i_ack), .i_starve(i_starve)
`ifdef HOPLITE_STATS_EN
        ,
        .defl_cnt(defl_cnt), .inj_cnt(inj_cnt)
`endif
    );

    function automatic pkt_t pk(input logic [1:0] x, input logic [1:0] y,
                                input logic [31:0] d, input logic v);
        pkt_t p;
        p.x = x;
        p.y = y;
        p.d = d;
        p.v = v;
        return p;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Drive a new input set just after the falling edge, then let comb logic settle.
    task automatic drive(input pkt_t n, input pkt_t w, input pkt_t i);
        @(negedge clk);
        n_x = n.x; n_y = n.y; n_d = n.d; n_v = n.v;
        w_x = w.x; w_y = w.y; w_d = w.d; w_v = w.v;
        i_x = i.x; i_y = i.y; i_d = i.d; i_v = i.v;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[11];
    pkt_t z;

    initial begin
        z = pk(2'd0, 2'd0, 32'h0, 1'b0);

        vecs[0]  = '{pk(1,2,32'hA,1), z, z, 1'b0, z, z, 1'b1, 32'hA};
        vecs[1]  = '{pk(1,0,32'hB,1), pk(1,3,32'hC,1), pk(1,0,32'h5,1), 1'b0,
                     pk(1,3,32'hC,1), pk(1,0,32'hB,1), 1'b0, 32'h0};
        vecs[2]  = '{pk(1,0,32'hB,1), pk(1,3,32'hC,1), pk(0,0,32'h6,1), 1'b0,
                     pk(1,3,32'hC,1), pk(1,0,32'hB,1), 1'b0, 32'h0};
        vecs[3]  = '{z, pk(0,0,32'h1,1), pk(1,0,32'h2,1), 1'b1,
                     pk(0,0,32'h1,1), pk(1,0,32'h2,1), 1'b0, 32'h0};
        vecs[4]  = '{z, pk(1,2,32'h7,1), z, 1'b0, z, z, 1'b1, 32'h7};
        vecs[5]  = '{z, z, pk(1,2,32'h8,1), 1'b1, z, z, 1'b1, 32'h8};
        vecs[6]  = '{z, z, pk(3,1,32'h9,1), 1'b1, pk(3,1,32'h9,1), z, 1'b0, 32'h0};
        vecs[7]  = '{z, pk(2,1,32'h10,1), pk(3,3,32'h11,1), 1'b0,
                     pk(2,1,32'h10,1), z, 1'b0, 32'h0};
        vecs[8]  = '{pk(0,0,32'h12,1), z, pk(2,2,32'h13,1), 1'b1,
                     pk(2,2,32'h13,1), pk(0,0,32'h12,1), 1'b0, 32'h0};
        vecs[9]  = '{z, z, z, 1'b0, z, z, 1'b0, 32'h0};
        vecs[10] = '{z, pk(1,1,32'h14,1), pk(1,0,32'h15,1), 1'b0,
                     z, pk(1,1,32'h14,1), 1'b0, 32'h0};

        // Reset state
        tick();
        tick();
        chk("rst_e_v", 32'(e_v), 0);
        chk("rst_s_v", 32'(s_v), 0);
        chk("rst_o_v", 32'(o_v), 0);
        chk("rst_starve", 32'(i_starve), 0);
        chk("rst_e_d", e_d, 0);
        chk("rst_s_d", s_d, 0);
        chk("rst_o_d", o_d, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 11; k++) begin
            drive(vecs[k].n, vecs[k].w, vecs[k].i);
            chk($sformatf("v%0d_ack", k), 32'(i_ack), 32'(vecs[k].ack));
            tick();
            chk($sformatf("v%0d_e_v", k), 32'(e_v), 32'(vecs[k].e.v));
            chk($sformatf("v%0d_s_v", k), 32'(s_v), 32'(vecs[k].s.v));
            chk($sformatf("v%0d_o_v", k), 32'(o_v), 32'(vecs[k].ov));
            if (vecs[k].e.v) begin
                chk($sformatf("v%0d_e_x", k), 32'(e_x), 32'(vecs[k].e.x));
                chk($sformatf("v%0d_e_d", k), e_d, vecs[k].e.d);
            end
            if (vecs[k].s.v) chk($sformatf("v%0d_s_d", k), s_d, vecs[k].s.d);
            if (vecs[k].ov) chk($sformatf("v%0d_o_d", k), o_d, vecs[k].od);
        end

        // Data fields hold while the channel is idle
        drive(z, z, pk(3,1,32'h33,1));
        tick();
        chk("hold_e_d0", e_d, 32'h33);
        drive(z, z, z);
        tick();
        chk("hold_e_v", 32'(e_v), 0);
        chk("hold_e_d1", e_d, 32'h33);

        // Clear counter, then starve the PE behind W for three cycles
        @(negedge clk); rst = 1'b1;
        tick();
        @(negedge clk); rst = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            drive(z, pk(1,0,32'h20 + 32'(c),1), pk(1,0,32'h55,1));
            chk($sformatf("starve_c%0d_ack", c), 32'(i_ack), 0);
            chk($sformatf("starve_c%0d_flag", c), 32'(i_starve), 0);
            tick();
            chk($sformatf("starve_c%0d_s_d", c), s_d, 32'h20 + 32'(c));
        end
        drive(z, pk(1,0,32'h24,1), pk(1,0,32'h55,1));
        chk("starve_c4_flag", 32'(i_starve), 1);
        chk("starve_c4_ack", 32'(i_ack), 1);
        tick();
        chk("starve_s_d", s_d, 32'h55);
        chk("starve_e_d", e_d, 32'h24);
        chk("starve_e_v", 32'(e_v), 1);
        drive(z, z, z);
        chk("starve_clear", 32'(i_starve), 0);

        // Reset mid-stream with counter part-way and outputs valid
        for (int c = 0; c < 2; c++) begin
            drive(pk(1,0,32'h40,1), pk(1,3,32'h41,1), pk(1,0,32'h42,1));
            tick();
        end
        chk("mid_pre_e_v", 32'(e_v), 1);
        chk("mid_pre_s_v", 32'(s_v), 1);
        @(negedge clk);
        rst = 1'b1;
        n_v = 1'b0; w_v = 1'b0;
        i_x = 2'd1; i_y = 2'd2; i_d = 32'h43; i_v = 1'b1;
        #1;
        chk("mid_rst_ack", 32'(i_ack), 0);
        tick();
        chk("mid_e_v", 32'(e_v), 0);
        chk("mid_s_v", 32'(s_v), 0);
        chk("mid_o_v", 32'(o_v), 0);
        chk("mid_starve", 32'(i_starve), 0);
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            drive(z, pk(1,0,32'h50,1), pk(1,0,32'h51,1));
            tick();
        end
        drive(z, pk(1,0,32'h50,1), pk(1,0,32'h51,1));
        chk("mid_restart_flag0", 32'(i_starve), 0);
        tick();
        drive(z, pk(1,0,32'h50,1), pk(1,0,32'h51,1));
        chk("mid_restart_flag1", 32'(i_starve), 1);
        tick();

`ifdef HOPLITE_STATS_EN
        @(negedge clk); rst = 1'b1;
        tick();
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            drive(pk(1,0,32'h60,1), pk(1,3,32'h61,1), z);
            tick();
        end
        for (int c = 0; c < 2; c++) begin
            drive(z, z, pk(1,2,32'h62,1));
            tick();
        end
        drive(z, z, z);
        tick();
        chk("stats_defl", 32'(defl_cnt), 5);
        chk("stats_inj", 32'(inj_cnt), 2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
